// File: rtl/signext.sv
// Immediate sign/zero/upper extension with combinational flags and an optional
// registered copy of the sign-extended value.
module signext #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic             en,
  output logic [OUT_W-1:0] y,
  output logic [OUT_W-1:0] y_zext,
  output logic [OUT_W-1:0] y_upper,
  output logic             is_neg,
  output logic             is_zero,
  output logic             is_ones,
  output logic [OUT_W-1:0] y_q,
  output logic             y_q_valid
);

  logic [OUT_W-1:0] cap_d, cap_q;
  logic             cap_valid_d, cap_valid_q;

  // Replication by zero is illegal, so the equal-width case is handled apart.
  if (OUT_W > IN_W) begin : g_ext
    assign y      = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
    assign y_zext = {{(OUT_W-IN_W){1'b0}}, a};
  end else begin : g_same
    assign y      = a;
    assign y_zext = a;
  end

  if (OUT_W >= 2*IN_W) begin : g_upper
    assign y_upper = {a, {(OUT_W-IN_W){1'b0}}};
  end else begin : g_no_upper
    assign y_upper = '0;
  end

  assign is_neg  = a[IN_W-1];
  assign is_zero = (a == '0);
  assign is_ones = &a;

  always_comb begin
    cap_d       = cap_q;
    cap_valid_d = cap_valid_q;
    if (en) begin
      cap_d       = y;
      cap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign y_q       = cap_q;
  assign y_q_valid = cap_valid_q;

endmodule

// File: tb/tb_signext.sv
// Directed, table-driven bench for signext: combinational extension, flags,
// an unclocked instance, an equal-width instance and the registered path.
module tb_signext;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] a;
  logic [31:0] y, y_zext, y_upper, y_q;
  logic        is_neg, is_zero, is_ones, y_q_valid;

  // Instance with clock/reset/en tied off: combinational path only.
  logic [15:0] a_nc;
  logic [31:0] y_nc, y_zext_nc, y_upper_nc, y_q_nc;
  logic        is_neg_nc, is_zero_nc, is_ones_nc, y_q_valid_nc;

  // Equal-width instance.
  logic [7:0] a8, y8, y_zext8, y_upper8, y_q8;
  logic       is_neg8, is_zero8, is_ones8, y_q_valid8;

  int n_vec;
  int n_fail;

  signext #(.IN_W(16), .OUT_W(32)) u_dut (
    .clk(clk), .reset(reset), .a(a), .en(en),
    .y(y), .y_zext(y_zext), .y_upper(y_upper),
    .is_neg(is_neg), .is_zero(is_zero), .is_ones(is_ones),
    .y_q(y_q), .y_q_valid(y_q_valid)
  );

  signext #(.IN_W(16), .OUT_W(32)) u_nc (
    .clk(1'b0), .reset(1'b0), .a(a_nc), .en(1'b0),
    .y(y_nc), .y_zext(y_zext_nc), .y_upper(y_upper_nc),
    .is_neg(is_neg_nc), .is_zero(is_zero_nc), .is_ones(is_ones_nc),
    .y_q(y_q_nc), .y_q_valid(y_q_valid_nc)
  );

  signext #(.IN_W(8), .OUT_W(8)) u_same (
    .clk(clk), .reset(reset), .a(a8), .en(1'b0),
    .y(y8), .y_zext(y_zext8), .y_upper(y_upper8),
    .is_neg(is_neg8), .is_zero(is_zero8), .is_ones(is_ones8),
    .y_q(y_q8), .y_q_valid(y_q_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [31:0] y;
    logic [31:0] zext;
    logic [31:0] upper;
    logic        neg;
    logic        zero;
    logic        ones;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b0;
    en     = 1'b0;
    a      = '0;
    a_nc   = '0;
    a8     = '0;

    vecs[0] = '{16'h0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0001, 32'h0000_0001, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 32'h0000_7FFF, 32'h0000_7FFF, 32'h7FFF_0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 32'hFFFF_8000, 32'h0000_8000, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'hFFF0, 32'hFFFF_FFF0, 32'h0000_FFF0, 32'hFFF0_0000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'hA5A5, 32'hFFFF_A5A5, 32'h0000_A5A5, 32'hA5A5_0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 32'h0000_1234, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0};

    // Combinational outputs of the clocked instance.
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a;
      #1;
      check($sformatf("y[%0d]", i),       y,       vecs[i].y);
      check($sformatf("y_zext[%0d]", i),  y_zext,  vecs[i].zext);
      check($sformatf("y_upper[%0d]", i), y_upper, vecs[i].upper);
      check($sformatf("is_neg[%0d]", i),  {31'd0, is_neg},  {31'd0, vecs[i].neg});
      check($sformatf("is_zero[%0d]", i), {31'd0, is_zero}, {31'd0, vecs[i].zero});
      check($sformatf("is_ones[%0d]", i), {31'd0, is_ones}, {31'd0, vecs[i].ones});
    end

    // Unclocked instance: step a every 10 time units.
    for (int i = 0; i < 8; i++) begin
      a_nc = vecs[i].a;
      #10;
      check($sformatf("nc_y[%0d]", i),    y_nc,    vecs[i].y);
      check($sformatf("nc_zext[%0d]", i), y_zext_nc, vecs[i].zext);
    end

    // Equal widths: y and y_zext pass a through, y_upper is zero.
    a8 = 8'h80;
    #1;
    check("same_y_80",     {24'd0, y8},       32'h0000_0080);
    check("same_zext_80",  {24'd0, y_zext8},  32'h0000_0080);
    check("same_upper_80", {24'd0, y_upper8}, 32'h0000_0000);
    a8 = 8'h7F;
    #1;
    check("same_y_7f",     {24'd0, y8},       32'h0000_007F);
    check("same_ones_7f",  {31'd0, is_ones8}, 32'h0000_0000);

    // Registered path.
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
    tick();
    check("rst_y_q",     y_q,               32'h0000_0000);
    check("rst_valid",   {31'd0, y_q_valid}, 32'h0000_0000);

    reset = 1'b0;
    en    = 1'b1;
    a     = 16'h8000;
    tick();
    check("cap_y_q",     y_q,               32'hFFFF_8000);
    check("cap_valid",   {31'd0, y_q_valid}, 32'h0000_0001);

    en = 1'b0;
    a  = 16'h1234;
    tick();
    check("hold_y_q",    y_q,               32'hFFFF_8000);
    check("hold_valid",  {31'd0, y_q_valid}, 32'h0000_0001);
    check("hold_y_comb", y,                 32'h0000_1234);

    en = 1'b1;
    tick();
    check("cap2_y_q",    y_q,               32'h0000_1234);

    // Reset wins over en; combinational output unaffected.
    reset = 1'b1;
    en    = 1'b1;
    a     = 16'hA5A5;
    tick();
    check("pri_y_q",     y_q,               32'h0000_0000);
    check("pri_valid",   {31'd0, y_q_valid}, 32'h0000_0000);
    check("pri_y_comb",  y,                 32'hFFFF_A5A5);
    check("pri_zext",    y_zext,            32'h0000_A5A5);

    reset = 1'b0;
    en    = 1'b0;
    tick();
    check("post_hold",   {31'd0, y_q_valid}, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/signext.md
SIGNEXT -- requirements
Module: signext

Interface
REQ-001 Parameter IN_W, default 16: input immediate width; SHALL be >= 2.
REQ-002 Parameter OUT_W, default 32: extended output width; SHALL be >= IN_W.
REQ-003 clk  input  1  system clock; the registered path samples on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-005 a  input  IN_W  immediate value to extend.
REQ-006 en  input  1  capture strobe for the registered path.
REQ-007 y  output  OUT_W  combinational sign extension of a.
REQ-008 y_zext  output  OUT_W  combinational zero extension of a.
REQ-009 y_upper  output  OUT_W  combinational a placed in the upper bits (lui form), low bits zero; defined only when OUT_W >= 2*IN_W, otherwise all zero.
REQ-010 is_neg  output  1  combinational copy of a[IN_W-1].
REQ-011 is_zero  output  1  combinational flag: a == 0.
REQ-012 is_ones  output  1  combinational flag: a is all ones (value -1).
REQ-013 y_q  output  OUT_W  registered copy of y.
REQ-014 y_q_valid  output  1  registered flag: y_q holds a captured value.

Function
REQ-015 y SHALL be {(OUT_W-IN_W) copies of a[IN_W-1], a}, with no clock dependence and zero latency.
REQ-016 y SHALL depend only on a; clk, reset and en SHALL NOT affect y, y_zext, y_upper or the flags, so the combinational path works with clk and reset unconnected.
REQ-017 y[IN_W-1:0] SHALL always equal a bit-for-bit.
REQ-018 When a[IN_W-1]=0, y[OUT_W-1:IN_W] SHALL be all zeros; when a[IN_W-1]=1, it SHALL be all ones.
REQ-019 The signed value of y SHALL equal the two's-complement value of a for every input; for the defaults, 0x8000 -> 0xFFFF8000 and 0x7FFF -> 0x00007FFF.
REQ-020 y_zext SHALL be {(OUT_W-IN_W) zeros, a}.
REQ-021 y_upper SHALL be {a, OUT_W-IN_W zeros} when OUT_W >= 2*IN_W.
REQ-022 is_zero and is_ones SHALL be mutually exclusive.
REQ-023 is_neg SHALL equal y[OUT_W-1].
REQ-024 On a rising clk with reset=0 and en=1, y_q SHALL load the current y and y_q_valid SHALL be set to 1; latency is 1 cycle.
REQ-025 On a rising clk with reset=0 and en=0, y_q and y_q_valid SHALL hold their values.
REQ-026 The outputs SHALL contain no X when a is fully driven.
REQ-027 When OUT_W == IN_W, y and y_zext SHALL both equal a.

Reset
REQ-028 On a rising clk with reset=1, y_q SHALL become 0 and y_q_valid SHALL become 0, regardless of en.
REQ-029 reset SHALL have priority over en within the same cycle.
REQ-030 Reset SHALL NOT affect the combinational outputs.
REQ-031 Between power-up and the first reset, y_q and y_q_valid are undefined.

Verification
REQ-032 Drive a = 0x0000, 0x0001, 0x7FFF -> y = 0x00000000, 0x00000001, 0x00007FFF; is_neg = 0.
REQ-033 Drive a = 0x8000, 0xFFFF, 0xFFF0, 0xA5A5 -> y = 0xFFFF8000, 0xFFFFFFFF, 0xFFFFFFF0, 0xFFFFA5A5; is_ones = 1 only for 0xFFFF.
REQ-034 Drive a = 0xA5A5 -> y_zext = 0x0000A5A5 and y_upper = 0xA5A50000.
REQ-035 With clk and reset left unconnected, stepping a every 10 time units -> y is correct after each step.
REQ-036 Hold reset high for 1 cycle, then set en=1 with a = 0x8000 -> y_q = 0xFFFF8000 and y_q_valid = 1 after one edge; with en=0 and a changed, y_q holds.
REQ-037 Assert reset and en together -> y_q = 0 and y_q_valid = 0.
